jtag_uart_tx_arbiter: RTL

//  Shares the single CPU->JTAG write port of jtag_uart (rx_data/rx_we/tx_full)

---
 rtl/jtag_uart_tx_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/jtag_uart_tx_arbiter.sv
// Round-robin, message-granular arbiter for the jtag_uart CPU->JTAG write port.
// A granted requester keeps the port until it sends EOM_CHAR, reaches the
// burst limit or goes idle, so lines from different sources never interleave.
module jtag_uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] EOM_CHAR     = 8'h0A,
  localparam int        IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data,
  output logic                 uart_we,
  input  logic                 uart_full,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id
);

  // Zero-limit configurations still need a one-bit counter to exist.
  localparam int BW = (MAX_BURST > 0)    ? $clog2(MAX_BURST + 1)    : 1;
  localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                   state, state_nxt;
  logic [IDW-1:0]           gid, gid_nxt;
  logic [IDW-1:0]           ptr, ptr_nxt;
  logic [BW-1:0]            burst_cnt, burst_nxt;
  logic [IW-1:0]            idle_cnt, idle_nxt;
  logic [NUM_REQ-1:0][7:0]  bytes;
  logic                     pick_vld;
  logic [IDW-1:0]           pick_id;
  logic                     own_vld;
  logic [7:0]               own_byte;
  logic                     xfer;
  logic                     burst_hit;
  logic                     idle_hit;
  logic                     rel;

  assign bytes       = req_data;
  assign own_vld     = req_valid[gid];
  assign own_byte    = bytes[gid];
  assign xfer        = (state == GRANT) & own_vld & ~uart_full;
  // Burst limit is hit by the transfer that brings the count up to MAX_BURST.
  assign burst_hit   = (MAX_BURST != 0) && (int'(burst_cnt) + 1 == MAX_BURST);
  // Idle limit is hit on the IDLE_TIMEOUT-th consecutive valid-low cycle.
  assign idle_hit    = ~own_vld && (int'(idle_cnt) + 1 >= IDLE_TIMEOUT);
  assign rel         = (state == GRANT) &&
                       ((xfer && ((own_byte == EOM_CHAR) || burst_hit)) || idle_hit);
  assign grant_valid = (state == GRANT);
  assign grant_id    = gid;

  // Round-robin pick: first valid index searching upward from ptr+1 with wrap.
  // Descending scan so the nearest candidate is assigned last and wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  // Next-state, counters and the combinational port mux.
  always_comb begin
    state_nxt = state;
    gid_nxt   = gid;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    idle_nxt  = idle_cnt;
    req_ready = '0;
    uart_we   = 1'b0;
    uart_data = 8'h00;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gid_nxt   = pick_id;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        req_ready[gid] = ~uart_full;
        uart_we        = xfer;
        uart_data      = own_byte;
        if (xfer) burst_nxt = burst_cnt + BW'(1);
        idle_nxt = own_vld ? '0 : idle_cnt + IW'(1);
        if (rel) begin
          state_nxt = IDLE;
          ptr_nxt   = gid;
          burst_nxt = '0;
          idle_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; ptr starts at the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gid       <= '0;
      ptr       <= IDW'(NUM_REQ - 1);
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gid       <= gid_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
      idle_cnt  <= idle_nxt;
    end
  end

endmodule
